// File: rtl/mod997_chunk_seq_pkg.sv
// Shared constants, FSM state type and modular helpers for the mod-997 chunk sequencer.
// Define MOD_SEQ_X500_EN to scale every residue by 500 (out_r = 500*X mod MOD).
package mod_seq_pkg;

    localparam int MOD     = 997;
    localparam int RES_W   = 10;
    localparam int CHUNK_W = 6;
    localparam int N_CHUNK = 10;
    localparam int X_W     = CHUNK_W * N_CHUNK;
    localparam int IDX_W   = $clog2(N_CHUNK);

`ifdef MOD_SEQ_X500_EN
    localparam int SCALE = 500;
`else
    localparam int SCALE = 1;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Both operands are already reduced, so one conditional subtract suffices.
    function automatic logic [RES_W-1:0] modadd(
        input logic [RES_W-1:0] a,
        input logic [RES_W-1:0] b
    );
        logic [RES_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (RES_W+1)'(MOD))
            s = s - (RES_W+1)'(MOD);
        return s[RES_W-1:0];
    endfunction

endpackage

// File: rtl/mod997_chunk_seq_if.sv
// Operand/result handshake bundle for the mod-997 chunk sequencer.
// The producer/consumer side uses master; the sequencer uses slave.
interface mod997_chunk_seq_if;
    import mod_seq_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [X_W-1:0]   in_x;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_r;
    logic             busy;

    modport master (
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_r, busy
    );

    modport slave (
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_r, busy
    );

endinterface

// File: rtl/mod997_chunk_seq_lut.sv
// Chunk-residue lookup: (SCALE * chunk * 2^(CHUNK_W*idx)) mod MOD.
// Table contents are computed at elaboration from MOD and SCALE.
module mod_chunk_lut
    import mod_seq_pkg::*;
(
    input  logic [CHUNK_W-1:0] chunk,
    input  logic [IDX_W-1:0]   idx,
    output logic [RES_W-1:0]   residue
);

    localparam int N_ENT    = 2 ** CHUNK_W;
    localparam int LUT_N    = N_CHUNK * N_ENT;
    localparam int LUT_BITS = LUT_N * RES_W;

    // Weight 2^(CHUNK_W*i) mod MOD is advanced per row to keep products small.
    function automatic logic [LUT_BITS-1:0] build_lut();
        logic [LUT_BITS-1:0] t;
        int w;
        int v;
        t = '0;
        w = 1;
        for (int i = 0; i < N_CHUNK; i++) begin
            for (int c = 0; c < N_ENT; c++) begin
                v = (((SCALE * c) % MOD) * w) % MOD;
                t[(i*N_ENT + c)*RES_W +: RES_W] = RES_W'(v);
            end
            w = (w * N_ENT) % MOD;
        end
        return t;
    endfunction

    localparam logic [LUT_BITS-1:0] TABLE = build_lut();

    logic [IDX_W+CHUNK_W-1:0] addr;

    assign addr = {idx, chunk};

    always_comb begin
        residue = '0;
        if (int'(addr) < LUT_N)
            residue = TABLE[int'(addr)*RES_W +: RES_W];
    end

endmodule

// File: rtl/mod997_chunk_seq.sv
// Sequential X mod 997 reducer: one chunk lookup and one modular add per cycle.
// With MOD_SEQ_X500_EN defined the result is (500*X) mod 997.
module mod997_chunk_seq
    import mod_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    mod997_chunk_seq_if.slave bus
);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [X_W-1:0]     x_q;
    logic [RES_W-1:0]   acc;
    logic [RES_W-1:0]   acc_nxt;
    logic [RES_W-1:0]   lut_r;
    logic [CHUNK_W-1:0] chunk;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [RES_W-1:0]   out_r_q;
    logic               busy_q;

    assign chunk   = x_q[int'(idx)*CHUNK_W +: CHUNK_W];
    assign acc_nxt = modadd(acc, lut_r);

    mod_chunk_lut u_lut (
        .chunk   (chunk),
        .idx     (idx),
        .residue (lut_r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            x_q         <= '0;
            acc         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_q        <= bus.in_x;
                        acc        <= '0;
                        idx        <= '0;
                        state      <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    // idx parks on the last chunk rather than wrapping.
                    if (idx == IDX_W'(N_CHUNK - 1)) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        out_r_q     <= acc_nxt;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_r     = out_r_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mod997_chunk_seq.sv
// Self-checking bench for mod997_chunk_seq against an arithmetic reference model.
// Honours MOD_SEQ_X500_EN the same way as the design build.
module tb_mod997_chunk_seq;

`ifdef MOD_SEQ_X500_EN
    localparam longint unsigned SC   = 500;
    localparam int              E1000 = 503;
    localparam int              EMAX  = 369;
`else
    localparam longint unsigned SC   = 1;
    localparam int              E1000 = 3;
    localparam int              EMAX  = 246;
`endif

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    mod997_chunk_seq_if bus ();

    mod997_chunk_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_mod(input logic [63:0] x);
        longint unsigned v;
        v = ((longint'(x) % 997) * SC) % 997;
        return int'(v);
    endfunction

    // Residue of the low k chunks only: what acc must hold after k folds.
    function automatic int ref_part(input logic [63:0] x, input int k);
        logic [63:0] m;
        m = (64'd1 << (6 * k)) - 64'd1;
        return ref_mod(x & m);
    endfunction

    task automatic send(input logic [59:0] x, output int lat, output int r);
        int n;
        bus.in_x      = x;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r = int'(bus.out_r);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.out_r !== 10'd0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: rdy=%b vld=%b r=%0d busy=%b want 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_r, bus.busy);
        end
        @(negedge clk);
        bus.in_x     = 60'd12345;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL run_busy: busy=%b want 1", bus.busy);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: busy=%b rdy=%b vld=%b want 0 1 0",
                     bus.busy, bus.in_ready, bus.out_valid);
        end
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_small();
        logic [59:0] xs [4];
        int          sp [4];
        int          lat;
        int          r;
        xs[0] = 60'd0;   sp[0] = 0;
        xs[1] = 60'd996; sp[1] = int'((996 * SC) % 997);
        xs[2] = 60'd997; sp[2] = 0;
        xs[3] = 60'd1000; sp[3] = E1000;
        for (int i = 0; i < 4; i++) begin
            send(xs[i], lat, r);
            tests++;
            if (r !== sp[i] || r !== ref_mod(64'(xs[i]))) begin
                fails++;
                $display("FAIL small_%0d: got %0d want %0d", i, r, sp[i]);
            end
            tests++;
            if (lat !== 10) begin
                fails++;
                $display("FAIL latency_%0d: got %0d want 10", i, lat);
            end
        end
    endtask

    task automatic test_max();
        logic [59:0] x;
        int          n;
        x = '1;
        bus.in_x      = x;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            tests++;
            if (int'(dut.acc) !== ref_part(64'(x), k)) begin
                fails++;
                $display("FAIL max_acc_%0d: got %0d want %0d",
                         k, dut.acc, ref_part(64'(x), k));
            end
        end
        n = 0;
        while (!bus.out_valid && n < 5) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (bus.out_valid !== 1'b1 || n !== 0 || int'(bus.out_r) !== EMAX) begin
            fails++;
            $display("FAIL max_result: vld=%b late=%0d got %0d want %0d",
                     bus.out_valid, n, bus.out_r, EMAX);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [59:0] x;
        int          n;
        int          r0;
        x = {$urandom, $urandom};
        bus.in_x      = x;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_x = ~x;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        r0 = int'(bus.out_r);
        tests++;
        if (r0 !== ref_mod(64'(x))) begin
            fails++;
            $display("FAIL bp_result: got %0d want %0d", r0, ref_mod(64'(x)));
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests++;
            if (bus.out_valid !== 1'b1 || int'(bus.out_r) !== r0 || bus.in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold_%0d: vld=%b r=%0d rdy=%b want 1 %0d 0",
                         i, bus.out_valid, bus.out_r, bus.in_ready, r0);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || int'(bus.out_r) !== r0) begin
            fails++;
            $display("FAIL bp_release: vld=%b rdy=%b r=%0d want 0 1 %0d",
                     bus.out_valid, bus.in_ready, bus.out_r, r0);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int lat;
        int r;
        int bad;
        bus.in_x      = 60'd1000;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
                bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL abort_no_output: %0d bad cycles want 0", bad);
        end
        send(60'd997, lat, r);
        tests++;
        if (r !== 0 || lat !== 10) begin
            fails++;
            $display("FAIL abort_next: r=%0d lat=%0d want 0 10", r, lat);
        end
    endtask

    task automatic test_stream();
        int          expq[$];
        int          sent;
        int          got;
        int          cyc;
        int          e;
        logic [59:0] x;
        sent = 0;
        got  = 0;
        cyc  = 0;
        while ((sent < 1000 || got < 1000) && cyc < 80000) begin
            if ($urandom_range(7) == 0)
                x = ($urandom_range(1) == 1) ? '1 : '0;
            else
                x = {$urandom, $urandom};
            bus.in_x      = x;
            bus.in_valid  = (sent < 1000) && ($urandom_range(1) == 1);
            bus.out_ready = ($urandom_range(1) == 1);
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back(ref_mod(64'(x)));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                e = (expq.size() > 0) ? expq.pop_front() : -1;
                got++;
                tests++;
                if (int'(bus.out_r) !== e) begin
                    fails++;
                    $display("FAIL stream_%0d: got %0d want %0d", got, bus.out_r, e);
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tests++;
        if (sent !== 1000 || got !== 1000 || expq.size() !== 0) begin
            fails++;
            $display("FAIL stream_count: sent=%0d got=%0d left=%0d want 1000 1000 0",
                     sent, got, expq.size());
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_small();
        test_max();
        test_backpressure();
        test_abort();
        test_stream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
